// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Brief    : AXI4-Lite bus bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/sys_regs.sv
`default_nettype none
// ============================================================================
// Module   : sys_regs
// Brief    : AXI4-Lite system registers: ID, version, scratch, LED control,
//            64-bit uptime counter with coherent LO/HI readout.
// Revision : 1.0 - initial release
// ============================================================================
module sys_regs #(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [31:0] ID_VALUE = 32'h00FB_0001,
    parameter logic [31:0] VERSION  = 32'h0001_0000
) (
    input  wire logic   aclk,
    input  wire logic   reset,
    axi4_lite_if.slave  bus,
    output logic        led_force,
    output logic        led_value
);
    generate
        if (DW != 32) begin : g_dw_check
            $error("sys_regs: DW must be 32");
        end
    endgenerate

    localparam logic [5:0] c_IDX_ID      = 6'd0;
    localparam logic [5:0] c_IDX_VERSION = 6'd1;
    localparam logic [5:0] c_IDX_SCRATCH = 6'd2;
    localparam logic [5:0] c_IDX_CTRL    = 6'd3;
    localparam logic [5:0] c_IDX_LO      = 6'd4;
    localparam logic [5:0] c_IDX_HI      = 6'd5;
    localparam logic [1:0] c_OKAY        = 2'b00;
    localparam logic [1:0] c_SLVERR      = 2'b10;

    logic        r_aw_full, r_w_full;
    logic [5:0]  r_aw_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_scratch;
    logic [1:0]  r_ctrl;
    logic [63:0] r_cnt;
    logic [31:0] r_hi_shadow;

    logic        w_awready, w_wready, w_arready;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic [5:0]  w_wr_idx, w_rd_idx;
    logic [31:0] w_wr_data, w_rd_data;
    logic [3:0]  w_wr_strb;
    logic        w_do_write, w_wr_err, w_rd_err, w_clr;
    logic        w_unused;

    assign w_unused = &{1'b0, bus.awaddr[AW-1:8], bus.awaddr[1:0],
                        bus.araddr[AW-1:8], bus.araddr[1:0]};

    assign w_awready = !reset && !r_aw_full && !r_bvalid;
    assign w_wready  = !reset && !r_w_full && !r_bvalid;
    assign w_arready = !reset && !r_rvalid;

    assign w_aw_hs = bus.awvalid && w_awready;
    assign w_w_hs  = bus.wvalid && w_wready;
    assign w_ar_hs = bus.arvalid && w_arready;
    assign w_b_hs  = r_bvalid && bus.bready;
    assign w_r_hs  = r_rvalid && bus.rready;

    // The update fires in the cycle of the second handshake, so take whichever
    // half is still on the bus directly instead of waiting for its capture.
    assign w_wr_idx   = r_aw_full ? r_aw_idx : bus.awaddr[7:2];
    assign w_wr_data  = r_w_full ? r_wdata : bus.wdata;
    assign w_wr_strb  = r_w_full ? r_wstrb : bus.wstrb;
    assign w_do_write = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs) && !r_bvalid;
    assign w_wr_err   = w_wr_idx > c_IDX_HI;
    assign w_clr      = w_do_write && (w_wr_idx == c_IDX_CTRL) && w_wr_strb[0] && w_wr_data[2];
    assign w_rd_idx   = bus.araddr[7:2];

    always_comb begin
        w_rd_data = 32'd0;
        w_rd_err  = 1'b0;
        case (w_rd_idx)
            c_IDX_ID:      w_rd_data = ID_VALUE;
            c_IDX_VERSION: w_rd_data = VERSION;
            c_IDX_SCRATCH: w_rd_data = r_scratch;
            c_IDX_CTRL:    w_rd_data = {30'd0, r_ctrl};
            c_IDX_LO:      w_rd_data = r_cnt[31:0];
            c_IDX_HI:      w_rd_data = r_hi_shadow;
            default:       w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_idx  <= 6'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_OKAY;
            r_rdata   <= 32'd0;
        end else begin
            if (w_b_hs) begin
                r_bvalid  <= 1'b0;
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= bus.awaddr[7:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= bus.wdata;
                r_wstrb  <= bus.wstrb;
            end
            if (w_do_write) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? c_SLVERR : c_OKAY;
            end
            if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_err ? c_SLVERR : c_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_scratch   <= 32'd0;
            r_ctrl      <= 2'd0;
            r_cnt       <= 64'd0;
            r_hi_shadow <= 32'd0;
        end else begin
            if (w_do_write && (w_wr_idx == c_IDX_SCRATCH)) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_wr_strb[i]) begin
                        r_scratch[8*i +: 8] <= w_wr_data[8*i +: 8];
                    end
                end
            end
            if (w_do_write && (w_wr_idx == c_IDX_CTRL) && w_wr_strb[0]) begin
                r_ctrl <= w_wr_data[1:0];
            end
            r_cnt <= w_clr ? 64'd0 : r_cnt + 64'd1;
            // HI is frozen from the same sample LO returns, giving a coherent pair.
            if (w_ar_hs && (w_rd_idx == c_IDX_LO)) begin
                r_hi_shadow <= r_cnt[63:32];
            end
        end
    end

    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.arready = w_arready;
    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.rvalid  = r_rvalid;
    assign bus.rresp   = r_rresp;
    assign bus.rdata   = r_rdata;
    assign led_force   = r_ctrl[0];
    assign led_value   = r_ctrl[1];
endmodule
`default_nettype wire

// File: tb/tb_sys_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_regs
// Brief    : Directed self-checking bench for sys_regs with a register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_regs;
    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   led_force, led_value;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    bit     chk_en = 1'b0;

    // Model state
    logic [31:0] m_scratch = 32'd0;
    logic [1:0]  m_ctrl = 2'd0;
    logic [31:0] m_hi = 32'd0;
    longint      m_base_cyc = 0;
    logic [63:0] m_base_val = 64'd0;

    axi4_lite_if #(.AW(32), .DW(32)) bus ();

    sys_regs #(.AW(32), .DW(32)) dut (
        .aclk      (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .led_force (led_force),
        .led_value (led_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model_cnt(input longint c);
        return m_base_val + 64'(c - m_base_cyc);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("led_force", {63'd0, led_force}, {63'd0, m_ctrl[0]});
            check("led_value", {63'd0, led_value}, {63'd0, m_ctrl[1]});
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        m_ctrl = 2'd0; m_scratch = 32'd0; m_hi = 32'd0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {41'd0, bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                             bus.bresp, bus.rresp, bus.rdata, led_force, led_value}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_base_cyc = cyc;
        m_base_val = 64'd0;
        @(negedge clk);
        check("ready_after_reset", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r,
                           output longint hc);
        int k;
        bit ok;
        k = 0; ok = 1'b0; hc = -1; d = 32'd0; r = 2'd0;
        @(posedge clk); #1;
        bus.arvalid = 1'b1;
        bus.araddr  = {24'd0, a};
        while (!ok && k < 20) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1'b1; hc = cyc; end
            @(posedge clk); #1;
            k++;
        end
        bus.arvalid = 1'b0;
        if (!ok) begin
            check("ar_timeout", 64'd0, 64'd1);
            return;
        end
        @(negedge clk);
        check("rvalid_latency", {63'd0, bus.rvalid}, 64'd1);
        d = bus.rdata;
        r = bus.rresp;
        if (a == 8'h10) m_hi = model_cnt(hc) >> 32;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int bhold);
        int     k;
        bit     aw_done, w_done;
        longint c_aw, c_w, n;
        k = 0; aw_done = 1'b0; w_done = 1'b0; c_aw = 0; c_w = 0;
        @(posedge clk); #1;
        bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
        bus.awaddr = {24'd0, a};
        bus.awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && k < 40) begin
            @(negedge clk);
            if (bus.awvalid && bus.awready) begin aw_done = 1'b1; c_aw = cyc; end
            if (bus.wvalid && bus.wready) begin w_done = 1'b1; c_w = cyc; end
            @(posedge clk); #1;
            k++;
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
            if (!aw_done && k >= w_lead) bus.awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            check("aw_w_timeout", 64'd0, 64'd1);
            return;
        end
        n = (c_aw > c_w) ? c_aw : c_w;
        // Now in cycle n+1: registers and LED outputs reflect the write.
        if (a < 8'h18) begin
            if (a[7:2] == 6'd2) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
            end
            if (a[7:2] == 6'd3 && s[0]) begin
                m_ctrl = d[1:0];
                if (d[2]) begin m_base_cyc = n + 1; m_base_val = 64'd0; end
            end
        end
        bus.bready = (bhold == 0);
        @(negedge clk);
        check("bvalid_latency", {63'd0, bus.bvalid}, 64'd1);
        check("bresp", {62'd0, bus.bresp}, (a >= 8'h18) ? 64'd2 : 64'd0);
        for (int i = 0; i < bhold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bhold_state", {61'd0, bus.bvalid, bus.awready, bus.wready}, 64'd4);
        end
        if (bhold > 0) begin
            @(posedge clk); #1;
            bus.bready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid_cleared", {63'd0, bus.bvalid}, 64'd0);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    longint      hc;

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.bready = 1'b1; bus.rready = 1'b1;

        do_reset(3);
        chk_en = 1'b1;

        do_read(8'h00, d, r, hc);
        check("id", {32'd0, d}, 64'h00FB_0001);
        check("id_resp", {62'd0, r}, 64'd0);
        do_read(8'h04, d, r, hc);
        check("version", {32'd0, d}, 64'h0001_0000);

        do_write(8'h08, 32'hDEAD_BEEF, 4'hF, 3, 0);
        do_write(8'h08, 32'h1122_3344, 4'b0101, 0, 0);
        do_read(8'h08, d, r, hc);
        check("scratch_literal", {32'd0, d}, 64'hDE22_BE44);
        check("scratch_model", {32'd0, d}, {32'd0, m_scratch});

        do_write(8'h0C, 32'h3, 4'hF, 0, 0);
        do_read(8'h0C, d, r, hc);
        check("ctrl_rb3", {32'd0, d}, 64'h3);
        do_write(8'h0C, 32'h0, 4'hF, 2, 0);
        do_read(8'h0C, d, r, hc);
        check("ctrl_rb0", {32'd0, d}, 64'h0);

        @(posedge clk); #2;
        dut.r_cnt = 64'h0000_0000_FFFF_FFFE;
        m_base_cyc = cyc;
        m_base_val = 64'h0000_0000_FFFF_FFFE;
        do_read(8'h10, d, r, hc);
        check("uptime_lo_literal", {32'd0, d}, 64'hFFFF_FFFF);
        check("uptime_lo_model", {32'd0, d}, {32'd0, model_cnt(hc) & 64'hFFFF_FFFF});
        repeat (10) @(posedge clk);
        do_read(8'h14, d, r, hc);
        check("uptime_hi_literal", {32'd0, d}, 64'd0);
        check("uptime_hi_model", {32'd0, d}, {32'd0, m_hi});

        do_write(8'h0C, 32'h4, 4'h1, 1, 0);
        do_read(8'h10, d, r, hc);
        check("uptime_after_clr", {32'd0, d}, {32'd0, model_cnt(hc) & 64'hFFFF_FFFF});
        check("uptime_small", {63'd0, (d < 32'd16)}, 64'd1);
        do_read(8'h0C, d, r, hc);
        check("ctrl_clr_reads0", {32'd0, d}, 64'd0);

        do_read(8'h40, d, r, hc);
        check("unmapped_rdata", {32'd0, d}, 64'd0);
        check("unmapped_rresp", {62'd0, r}, 64'd2);
        do_write(8'h18, 32'hFFFF_FFFF, 4'hF, 0, 0);
        do_read(8'h08, d, r, hc);
        check("scratch_after_slverr", {32'd0, d}, {32'd0, m_scratch});

        do_write(8'h08, 32'hCAFE_F00D, 4'hF, 0, 5);
        do_read(8'h08, d, r, hc);
        check("scratch_cafe", {32'd0, d}, 64'hCAFE_F00D);

        // Reset while a B response is pending.
        @(posedge clk); #1;
        bus.bready = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 32'h08;
        bus.wvalid = 1'b1; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        check("bvalid_before_reset", {63'd0, bus.bvalid}, 64'd1);
        do_reset(2);
        do_read(8'h08, d, r, hc);
        check("scratch_after_reset", {32'd0, d}, 64'd0);
        do_read(8'h10, d, r, hc);
        check("uptime_after_reset", {32'd0, d}, {32'd0, model_cnt(hc) & 64'hFFFF_FFFF});

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
